// File: rtl/load_extract_unit.sv
// Sequential load path: one aligned doubleword read per request, then low-byte extraction with sign/zero extension.
// Optional WAIT timeout is built only when LOAD_TIMEOUT_EN is defined.
module load_extract_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_lmt,
   input  logic        req_unsigned,
   output logic        mem_rd_en,
   output logic [63:0] mem_addr,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic        resp_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [1:0] LMT_D = 2'b00;
   localparam logic [1:0] LMT_W = 2'b01;
   localparam logic [1:0] LMT_H = 2'b10;
   localparam logic [1:0] LMT_B = 2'b11;

   state_t      state_q, state_d;
   logic [60:0] addr_q, addr_d;
   logic [1:0]  lmt_q, lmt_d;
   logic        uns_q, uns_d;
   logic [63:0] data_q, data_d;

   // Lane select is fixed to the low bytes so loads mirror the store merge exactly.
   function automatic logic [63:0] extract(input logic [63:0] rd,
                                           input logic [1:0]  lmt,
                                           input logic        uns);
      logic [63:0] res;
      case (lmt)
         LMT_D:   res = rd;
         LMT_W:   res = {{32{~uns & rd[31]}}, rd[31:0]};
         LMT_H:   res = {{48{~uns & rd[15]}}, rd[15:0]};
         LMT_B:   res = {{56{~uns & rd[7]}},  rd[7:0]};
         default: res = rd;
      endcase
      return res;
   endfunction

`ifdef LOAD_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             expire;

   // Counter holds the number of WAIT cycles already spent; the last allowed one expires.
   assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         lmt_q   <= '0;
         uns_q   <= 1'b0;
         data_q  <= '0;
`ifdef LOAD_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lmt_q   <= lmt_d;
         uns_q   <= uns_d;
         data_q  <= data_d;
`ifdef LOAD_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lmt_d   = lmt_q;
      uns_d   = uns_q;
      data_d  = data_q;
`ifdef LOAD_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_REQ;
               addr_d  = req_addr[63:3];
               lmt_d   = req_lmt;
               uns_d   = req_unsigned;
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
`ifdef LOAD_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_d = S_RESP;
               data_d  = extract(mem_rdata, lmt_q, uns_q);
`ifdef LOAD_TIMEOUT_EN
               err_d   = 1'b0;
            end else if (expire) begin
               state_d = S_RESP;
               data_d  = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
`endif
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
`ifdef LOAD_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready  = (state_q == S_IDLE);
   assign mem_rd_en  = (state_q == S_REQ);
   assign mem_addr   = (state_q == S_IDLE) ? 64'd0 : {addr_q, 3'b000};
   assign resp_valid = (state_q == S_RESP);
   assign resp_data  = data_q;

`ifdef LOAD_TIMEOUT_EN
   assign resp_err   = err_q;
`else
   assign resp_err   = 1'b0;
`endif

   // Sub-doubleword address bits and the timeout setting are not needed in every build.
   logic unused_cfg;
   assign unused_cfg = ^req_addr[2:0] ^ (TIMEOUT_CYCLES == 0);

endmodule

// File: tb/tb_load_extract_unit.sv
// Directed bench for load_extract_unit; define LOAD_TIMEOUT_EN to also exercise the timeout path.
module tb_load_extract_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic [1:0]  req_lmt;
   logic        req_unsigned;
   logic        mem_rd_en;
   logic [63:0] mem_addr;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic        resp_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

`ifdef LOAD_TIMEOUT_EN
   load_extract_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
   load_extract_unit dut (
`endif
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_lmt      (req_lmt),
      .req_unsigned (req_unsigned),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_err     (resp_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_req_ready"},  64'(req_ready),  64'd1);
      check({tag, "_mem_rd_en"},  64'(mem_rd_en),  64'd0);
      check({tag, "_mem_addr"},   mem_addr,        64'd0);
      check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      check({tag, "_resp_err"},   64'(resp_err),   64'd0);
   endtask

   // One complete load; gap = WAIT cycles before mem_rvalid, give = 0 withholds the response.
   task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] lmt,
                          input logic uns, input logic [63:0] rd, input int gap,
                          input logic give, input logic [63:0] exp, input logic exp_err);
      logic [63:0] aligned;
      aligned = {addr[63:3], 3'b000};
      check({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_addr = addr; req_lmt = lmt; req_unsigned = uns;
      cyc();
      req_valid = 1'b0; req_addr = '0; req_lmt = 2'b00; req_unsigned = 1'b0;
      check({tag, "_rd_en_req"},  64'(mem_rd_en), 64'd1);
      check({tag, "_addr_req"},   mem_addr,       aligned);
      check({tag, "_ready_req"},  64'(req_ready), 64'd0);
      mem_rvalid = 1'b1; mem_rdata = ~rd;
      cyc();
      mem_rvalid = 1'b0; mem_rdata = '0;
      for (int i = 0; i < gap; i++) begin
         check({tag, "_valid_wait"}, 64'(resp_valid), 64'd0);
         check({tag, "_rd_en_wait"}, 64'(mem_rd_en),  64'd0);
         check({tag, "_addr_wait"},  mem_addr,        aligned);
         cyc();
      end
      if (give) begin
         mem_rvalid = 1'b1; mem_rdata = rd;
      end
      cyc();
      mem_rvalid = 1'b0; mem_rdata = '0;
      check({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
      check({tag, "_resp_data"},  resp_data,       exp);
      check({tag, "_resp_err"},   64'(resp_err),   64'(exp_err));
      check({tag, "_addr_resp"},  mem_addr,        aligned);
      resp_ready = 1'b1;
      cyc();
      resp_ready = 1'b0;
      check_idle({tag, "_after"});
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_lmt = 2'b00; req_unsigned = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
      @(negedge clk);
      check_idle("reset");
      check("reset_resp_data", resp_data, 64'd0);
      rst_n = 1'b1;
      cyc();

      do_load("lb_s",  64'h2003, 2'b11, 1'b0, 64'h1122334455667780, 0, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0);
      do_load("lbu",   64'h2003, 2'b11, 1'b1, 64'h1122334455667780, 1, 1'b1, 64'h0000000000000080, 1'b0);
      do_load("lhu",   64'h0010, 2'b10, 1'b1, 64'hAAAABBBBCCCC8001, 2, 1'b1, 64'h0000000000008001, 1'b0);
      do_load("lh_s",  64'h0012, 2'b10, 1'b0, 64'hAAAABBBBCCCC8001, 0, 1'b1, 64'hFFFFFFFFFFFF8001, 1'b0);
      do_load("lw_s",  64'h0024, 2'b01, 1'b0, 64'h0000000080000000, 0, 1'b1, 64'hFFFFFFFF80000000, 1'b0);
      do_load("lwu",   64'h0024, 2'b01, 1'b1, 64'h0000000080000000, 1, 1'b1, 64'h0000000080000000, 1'b0);
      do_load("lw_pos",64'h0020, 2'b01, 1'b0, 64'hFFFFFFFF7FFFFFFF, 0, 1'b1, 64'h000000007FFFFFFF, 1'b0);
      do_load("ld",    64'h1007, 2'b00, 1'b0, 64'hDEADBEEFCAFEF00D, 0, 1'b1, 64'hDEADBEEFCAFEF00D, 1'b0);
      do_load("ld_u",  64'hFFFFFFFFFFFFFFFF, 2'b00, 1'b1, 64'h8000000000000001, 3, 1'b1,
              64'h8000000000000001, 1'b0);

      // Backpressure: result must hold while the consumer stalls.
      req_valid = 1'b1; req_addr = 64'h3005; req_lmt = 2'b11; req_unsigned = 1'b0;
      cyc();
      req_valid = 1'b0;
      cyc();
      mem_rvalid = 1'b1; mem_rdata = 64'h00000000000000F3;
      cyc();
      mem_rvalid = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 5; i++) begin
         req_valid = ~req_valid; req_lmt = 2'b00;
         check("bp_resp_valid", 64'(resp_valid), 64'd1);
         check("bp_resp_data",  resp_data,       64'hFFFFFFFFFFFFFFF3);
         check("bp_req_ready",  64'(req_ready),  64'd0);
         check("bp_rd_en",      64'(mem_rd_en),  64'd0);
         check("bp_mem_addr",   mem_addr,        64'h3000);
         cyc();
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      cyc();
      resp_ready = 1'b0;
      check_idle("bp_after");

      // Reset in WAIT, then a late response must be ignored.
      req_valid = 1'b1; req_addr = 64'h4008; req_lmt = 2'b00; req_unsigned = 1'b0;
      cyc();
      req_valid = 1'b0;
      cyc();
      check("rst_pre_addr", mem_addr, 64'h4008);
      rst_n = 1'b0;
      #1;
      check_idle("rst_async");
      check("rst_async_data", resp_data, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 64'h123456789ABCDEF0;
      cyc();
      mem_rvalid = 1'b0; mem_rdata = '0;
      cyc();
      check_idle("rst_late");
      check("rst_late_data", resp_data, 64'd0);

`ifdef LOAD_TIMEOUT_EN
      do_load("to_none", 64'h5000, 2'b00, 1'b0, 64'h0123456789ABCDEF, 3, 1'b0, 64'd0, 1'b1);
      do_load("to_edge", 64'h5000, 2'b00, 1'b0, 64'h0123456789ABCDEF, 3, 1'b1,
              64'h0123456789ABCDEF, 1'b0);
      do_load("to_lb",   64'h5001, 2'b11, 1'b1, 64'h00000000000000AB, 2, 1'b1,
              64'h00000000000000AB, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
